array_mac_multiplier: RTL and testbench

- Parametrised successor to the pipelined array multiplier.
- Adds a per-transaction signed/unsigned mode using Baugh-Wooley partial-product inversion, valid/ready backpressure, an in-flight counter, and an output-stage accumulator with clear and a sticky overflow flag.
- Sits in datapath MAC lanes and feeds retiming experiments.
- Internal register stages are placed between partial-product rows, as in the existing multiplier.

---
 rtl/array_mac_multiplier.sv | 182 ++++++++++++++++++
 tb/tb_array_mac_multiplier.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/array_mac_multiplier.sv
// Pipelined Baugh-Wooley array multiplier with a per-transaction signed/unsigned
// mode, valid/ready backpressure, an in-flight counter and an output accumulator.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_valid, o_ready  input handshake (o_ready = !o_valid || i_ready)
//   A, B              operands, DATAWIDTH bits each
//   i_signed          1 = two's-complement operands, 0 = unsigned
//   i_acc_en          add this product into the accumulator
//   i_acc_clr         zero the accumulator before this transaction's add
//   o_valid, i_ready  output handshake
//   Z_final           2*DATAWIDTH-bit product
//   o_acc, o_acc_ovf  accumulator value and sticky overflow flag
//   o_inflight        accepted transactions not yet consumed
module array_mac_multiplier #(
  parameter int DATAWIDTH           = 8,
  parameter int NUM_PIPELINE_STAGES = 2,
  parameter int ACC_WIDTH           = 2*DATAWIDTH+8,
  parameter int INSTANCE_ID         = 0
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     i_valid,
  output logic                                     o_ready,
  input  logic [DATAWIDTH-1:0]                     A,
  input  logic [DATAWIDTH-1:0]                     B,
  input  logic                                     i_signed,
  input  logic                                     i_acc_en,
  input  logic                                     i_acc_clr,
  output logic                                     o_valid,
  input  logic                                     i_ready,
  output logic [2*DATAWIDTH-1:0]                   Z_final,
  output logic [ACC_WIDTH-1:0]                     o_acc,
  output logic                                     o_acc_ovf,
  output logic [$clog2(NUM_PIPELINE_STAGES+3)-1:0] o_inflight
);

  localparam int W  = DATAWIDTH;
  localparam int S  = NUM_PIPELINE_STAGES;
  localparam int PW = 2*W;
  localparam int IW = $clog2(S+3);

  // Baugh-Wooley correction constant: 2^W + 2^(2W-1)
  localparam logic [PW-1:0] BW_C =
    {1'b1, {(W-2){1'b0}}, 1'b1, {W{1'b0}}};

  if (DATAWIDTH < 4 || DATAWIDTH > 32 || S < 0 || S > DATAWIDTH ||
      ACC_WIDTH < 2*DATAWIDTH || INSTANCE_ID < 0) begin : g_bad_param
    $error("array_mac_multiplier: illegal parameterisation");
  end

  // First partial-product row handled after register k (rows split evenly
  // over S+1 combinational segments).
  function automatic int bnd(input int k);
    return (k*W)/(S+1);
  endfunction

  // One partial-product row, shifted into place. In signed mode the bits that
  // pair exactly one operand MSB are inverted.
  function automatic logic [PW-1:0] row_val(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         sgn,
    input int           i
  );
    logic [W-1:0] bits;
    bits = '0;
    for (int j = 0; j < W; j++)
      bits[j] = (a[j] & b[i]) ^ (sgn & ((i == W-1) != (j == W-1)));
    return PW'(bits) << i;
  endfunction

  function automatic logic [PW-1:0] seg(
    input logic [PW-1:0] s,
    input logic [W-1:0]  a,
    input logic [W-1:0]  b,
    input logic          sgn,
    input int            lo,
    input int            hi
  );
    logic [PW-1:0] r;
    r = s;
    for (int i = 0; i < W; i++)
      if (i >= lo && i < hi) r = r + row_val(a, b, sgn, i);
    return r;
  endfunction

  logic advance;
  assign advance = !o_valid || i_ready;
  assign o_ready = advance;

  // Index 0 is the input register, 1..S the internal stages.
  logic          st_v   [S+1];
  logic [W-1:0]  st_a   [S+1];
  logic [W-1:0]  st_b   [S+1];
  logic          st_sgn [S+1];
  logic          st_en  [S+1];
  logic          st_clr [S+1];
  logic [PW-1:0] st_sum [S+1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= S; k++) begin
        st_v[k]   <= 1'b0;
        st_a[k]   <= '0;
        st_b[k]   <= '0;
        st_sgn[k] <= 1'b0;
        st_en[k]  <= 1'b0;
        st_clr[k] <= 1'b0;
        st_sum[k] <= '0;
      end
    end else if (advance) begin
      // Empty slots carry zeroed operands and tags.
      st_v[0]   <= i_valid;
      st_a[0]   <= i_valid ? A : '0;
      st_b[0]   <= i_valid ? B : '0;
      st_sgn[0] <= i_valid & i_signed;
      st_en[0]  <= i_valid & i_acc_en;
      st_clr[0] <= i_valid & i_acc_clr;
      st_sum[0] <= (i_valid && i_signed) ? BW_C : '0;
      for (int k = 1; k <= S; k++) begin
        st_v[k]   <= st_v[k-1];
        st_a[k]   <= st_a[k-1];
        st_b[k]   <= st_b[k-1];
        st_sgn[k] <= st_sgn[k-1];
        st_en[k]  <= st_en[k-1];
        st_clr[k] <= st_clr[k-1];
        st_sum[k] <= seg(st_sum[k-1], st_a[k-1], st_b[k-1],
                         st_sgn[k-1], bnd(k-1), bnd(k));
      end
    end
  end

  logic [PW-1:0]        prod;
  logic [ACC_WIDTH-1:0] ext;
  logic [ACC_WIDTH-1:0] base;
  logic [ACC_WIDTH:0]   sum;
  logic                 add_ovf;

  always_comb begin
    prod = seg(st_sum[S], st_a[S], st_b[S], st_sgn[S], bnd(S), W);
    ext  = st_sgn[S] ? ACC_WIDTH'($signed(prod)) : ACC_WIDTH'(prod);
    base = st_clr[S] ? '0 : o_acc;
    sum  = {1'b0, base} + {1'b0, ext};
    if (st_sgn[S])
      add_ovf = (base[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
                (sum[ACC_WIDTH-1] != base[ACC_WIDTH-1]);
    else
      add_ovf = sum[ACC_WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid   <= 1'b0;
      Z_final   <= '0;
      o_acc     <= '0;
      o_acc_ovf <= 1'b0;
    end else if (advance) begin
      o_valid <= st_v[S];
      if (st_v[S]) begin
        Z_final   <= prod;
        o_acc     <= st_en[S] ? sum[ACC_WIDTH-1:0] : base;
        o_acc_ovf <= (o_acc_ovf && !st_clr[S]) || (st_en[S] && add_ovf);
      end
    end
  end

  logic take;
  logic give;
  assign take = i_valid && advance;
  assign give = o_valid && i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      o_inflight <= '0;
    else if (take && !give)
      o_inflight <= o_inflight + IW'(1);
    else if (!take && give)
      o_inflight <= o_inflight - IW'(1);
  end

endmodule

// File: tb/tb_array_mac_multiplier.sv
// Self-checking bench for array_mac_multiplier: vector table plus scoreboard,
// with latency, backpressure, overflow and mid-stream reset sequences.
module tb_array_mac_multiplier;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int AW = 24;
  localparam int IW = $clog2(S+3);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            i_valid = 1'b0;
  logic            o_ready;
  logic [W-1:0]    A = '0;
  logic [W-1:0]    B = '0;
  logic            i_signed = 1'b0;
  logic            i_acc_en = 1'b0;
  logic            i_acc_clr = 1'b0;
  logic            o_valid;
  logic            i_ready = 1'b1;
  logic [2*W-1:0]  Z_final;
  logic [AW-1:0]   o_acc;
  logic            o_acc_ovf;
  logic [IW-1:0]   o_inflight;

  array_mac_multiplier #(
    .DATAWIDTH(W), .NUM_PIPELINE_STAGES(S), .ACC_WIDTH(AW), .INSTANCE_ID(0)
  ) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .A(A), .B(B), .i_signed(i_signed), .i_acc_en(i_acc_en),
    .i_acc_clr(i_acc_clr), .o_valid(o_valid), .i_ready(i_ready),
    .Z_final(Z_final), .o_acc(o_acc), .o_acc_ovf(o_acc_ovf),
    .o_inflight(o_inflight)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] z;
    logic [AW-1:0]  acc;
    logic           ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sgn;
    logic           en;
    logic           clr;
    logic [2*W-1:0] z;
    logic [AW-1:0]  acc;
    logic           ovf;
  } vec_t;

  exp_t          sbq[$];
  int            checks = 0;
  int            errors = 0;
  int            pops = 0;
  int            peak = 0;
  logic [AW-1:0] m_acc = '0;
  logic          m_ovf = 1'b0;
  exp_t          first_exp;
  vec_t          tbl[12];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (int'(o_inflight) > peak) peak = int'(o_inflight);
      if (o_valid && i_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: z=0x%0h with no pending entry",
                   Z_final);
        end else begin
          e = sbq.pop_front();
          pops++;
          check("z", 64'(Z_final), 64'(e.z));
          check("acc", 64'(o_acc), 64'(e.acc));
          check("ovf", 64'(o_acc_ovf), 64'(e.ovf));
        end
      end
    end
  end

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sgn, input logic en, input logic clr,
                       output exp_t e);
    longint pa, pb, p, bs, s;
    logic [AW-1:0] bv;
    logic ovf_add;
    pa = sgn ? longint'($signed(a)) : longint'(a);
    pb = sgn ? longint'($signed(b)) : longint'(b);
    p  = pa * pb;
    bv = clr ? '0 : m_acc;
    bs = sgn ? longint'($signed(bv)) : longint'(bv);
    s = bs;
    ovf_add = 1'b0;
    if (en) begin
      s = bs + p;
      if (sgn)
        ovf_add = (s > (longint'(1) << (AW-1)) - 1) ||
                  (s < -(longint'(1) << (AW-1)));
      else
        ovf_add = (s >= (longint'(1) << AW));
    end
    e.z   = p[2*W-1:0];
    e.acc = s[AW-1:0];
    e.ovf = (m_ovf && !clr) || ovf_add;
    m_acc = e.acc;
    m_ovf = e.ovf;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic sgn, input logic en, input logic clr,
                      input exp_t e);
    int n;
    n = 0;
    A = a; B = b; i_signed = sgn;
    i_acc_en = en; i_acc_clr = clr; i_valid = 1'b1;
    #1;
    while (!o_ready && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (!o_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: o_ready=%0b required 1", o_ready);
    end else begin
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_m(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sgn, input logic en, input logic clr,
                        output exp_t e);
    model(a, b, sgn, en, clr, e);
    send(a, b, sgn, en, clr, e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results missing, required 0", sbq.size());
      sbq.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    exp_t e;
    int   lat;
    int   pops0;

    tbl[0]  = '{8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 16'hFE01, 24'h000000, 1'b0};
    tbl[1]  = '{8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 16'h4000, 24'h000000, 1'b0};
    tbl[2]  = '{8'hFF, 8'h7F, 1'b1, 1'b0, 1'b0, 16'hFF81, 24'h000000, 1'b0};
    tbl[3]  = '{8'h80, 8'hFF, 1'b0, 1'b0, 1'b0, 16'h7F80, 24'h000000, 1'b0};
    tbl[4]  = '{8'd10, 8'd10, 1'b1, 1'b1, 1'b1, 16'h0064, 24'd100, 1'b0};
    tbl[5]  = '{8'd20, 8'd3,  1'b1, 1'b1, 1'b0, 16'h003C, 24'd160, 1'b0};
    tbl[6]  = '{8'hFB, 8'd4,  1'b1, 1'b1, 1'b0, 16'hFFEC, 24'd140, 1'b0};
    tbl[7]  = '{8'd7,  8'd7,  1'b1, 1'b0, 1'b1, 16'h0031, 24'd0, 1'b0};
    tbl[8]  = '{8'h7F, 8'h7F, 1'b1, 1'b1, 1'b0, 16'h3F01, 24'h003F01, 1'b0};
    tbl[9]  = '{8'h80, 8'h7F, 1'b1, 1'b1, 1'b0, 16'hC080, 24'hFFFF81, 1'b0};
    tbl[10] = '{8'h80, 8'h02, 1'b0, 1'b1, 1'b0, 16'h0100, 24'h000081, 1'b1};
    tbl[11] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 16'h0000, 24'h000000, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_z", 64'(Z_final), 64'd0);
    check("rst_acc", 64'(o_acc), 64'd0);
    check("rst_ovf", 64'(o_acc_ovf), 64'd0);
    check("rst_inflight", 64'(o_inflight), 64'd0);
    check("rst_ready", 64'(o_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Latency, counting the acceptance edge as the first.
    send_m(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, e);
    i_valid = 1'b0;
    check("lat_inflight_1", 64'(o_inflight), 64'd1);
    lat = 1;
    while (!o_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(S+2));
    check("lat_z", 64'(Z_final), 64'h FE01);
    @(posedge clk);
    #1;
    check("lat_inflight_0", 64'(o_inflight), 64'd0);
    check("lat_valid_drop", 64'(o_valid), 64'd0);

    // Vector table, back to back.
    for (int i = 0; i < 12; i++) begin
      e.z   = tbl[i].z;
      e.acc = tbl[i].acc;
      e.ovf = tbl[i].ovf;
      send(tbl[i].a, tbl[i].b, tbl[i].sgn, tbl[i].en, tbl[i].clr, e);
    end
    i_valid = 1'b0;
    drain();
    m_acc = tbl[11].acc;
    m_ovf = tbl[11].ovf;

    // Unsigned overflow: 259 accumulations of 255*255, then a clear.
    for (int k = 1; k <= 260; k++) begin
      if (k == 259) begin
        e.z = 16'hFE01; e.acc = 24'h00FB03; e.ovf = 1'b1;
        send(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, e);
        m_acc = 24'h00FB03;
        m_ovf = 1'b1;
      end else begin
        send_m(8'hFF, 8'hFF, 1'b0, k != 260, k == 1 || k == 260, e);
      end
    end
    i_valid = 1'b0;
    drain();
    check("ovf_cleared", 64'(o_acc_ovf), 64'd0);
    check("ovf_clr_acc", 64'(o_acc), 64'd0);

    // Backpressure: 6 inputs, 3-cycle stall after the first result.
    peak = 0;
    pops0 = pops;
    fork
      begin : bp_src
        exp_t be;
        for (int i = 0; i < 6; i++) begin
          send_m(8'(i*37+5), 8'(250-i*13), 1'(i % 2), 1'b1, i == 0, be);
          if (i == 0) first_exp = be;
        end
        i_valid = 1'b0;
      end
      begin : bp_ctl
        int n;
        n = 0;
        while (!o_valid && n < 20) begin
          @(posedge clk);
          #1;
          n++;
        end
        check("bp_first_valid", 64'(o_valid), 64'd1);
        i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("bp_ready_low", 64'(o_ready), 64'd0);
          check("bp_valid_hold", 64'(o_valid), 64'd1);
          check("bp_z_hold", 64'(Z_final), 64'(first_exp.z));
          check("bp_acc_hold", 64'(o_acc), 64'(first_exp.acc));
          check("bp_inflight", 64'(o_inflight), 64'(S+2));
        end
        @(posedge clk);
        #1;
        i_ready = 1'b1;
      end
    join
    drain();
    check("bp_delivered", 64'(pops - pops0), 64'd6);
    check("bp_peak", 64'(peak), 64'(S+2));

    // Reset with three transactions in flight.
    for (int i = 0; i < 3; i++)
      send_m(8'(i+1), 8'(i+2), 1'b0, 1'b1, 1'b0, e);
    i_valid = 1'b0;
    check("mid_inflight", 64'(o_inflight), 64'd3);
    rst = 1'b1;
    #1;
    sbq.delete();
    m_acc = '0;
    m_ovf = 1'b0;
    check("mid_rst_valid", 64'(o_valid), 64'd0);
    check("mid_rst_z", 64'(Z_final), 64'd0);
    check("mid_rst_acc", 64'(o_acc), 64'd0);
    check("mid_rst_inflight", 64'(o_inflight), 64'd0);
    check("mid_rst_ready", 64'(o_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("no_ghost", 64'(o_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    send_m(8'd3, 8'd4, 1'b0, 1'b1, 1'b0, e);
    i_valid = 1'b0;
    drain();
    check("post_rst_acc", 64'(o_acc), 64'd12);
    check("post_rst_inflight", 64'(o_inflight), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
